// File: rtl/mips_pkg.sv
// Shared MIPS-style pipeline definitions: default widths, fetch FSM encoding,
// next-PC selector and offset sign extension.
package mips_pkg;

  localparam int              DEF_ADDR_W   = 16;
  localparam int              DEF_INSTR_W  = 32;
  localparam logic [15:0]     DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_op_t;

  // Wide enough for any PC width up to 32; callers size-cast the result.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC select; all arithmetic wraps modulo 2^ADDR_W.
module pc_next_logic
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  pc_op_t            op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [15:0]       br_offset,
  output logic [ADDR_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    case (op)
      PC_INC:    pc_nxt = pc + ADDR_W'(1);
      PC_JUMP:   pc_nxt = jump_target;
      PC_BRANCH: pc_nxt = pc + ADDR_W'(sext16(br_offset));
      default:   pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and 4-state instruction fetch sequencer driven by the control
// unit's one-hot IF/JU/BR/SK strobes; the BRAM lives outside behind imem_*.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               top_en,
  input  logic               IF,
  input  logic               JU,
  input  logic               BR,
  input  logic               SK,
  input  logic               cond,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [15:0]        br_offset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  fetch_state_t      state, state_nxt;
  pc_op_t            pc_op;
  logic [ADDR_W-1:0] pc_nxt;
  logic              fetch_go;
  logic              collide;
  logic              collision;

  pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
    .op          (pc_op),
    .pc          (pc),
    .jump_target (jump_target),
    .br_offset   (br_offset),
    .pc_nxt      (pc_nxt)
  );

  // Strobes only matter in IDLE with top_en; highest-priority one wins and
  // any lower one in the same cycle is dropped and logged in collision.
  always_comb begin
    state_nxt = state;
    pc_op     = PC_HOLD;
    fetch_go  = 1'b0;
    collide   = 1'b0;
    case (state)
      IDLE: begin
        if (top_en) begin
          if (IF) begin
            fetch_go  = 1'b1;
            state_nxt = REQ;
            collide   = JU | BR | SK;
          end else if (JU) begin
            pc_op   = PC_JUMP;
            collide = BR | SK;
          end else if (BR) begin
            if (cond) pc_op = PC_BRANCH;
            collide = SK;
          end else if (SK) begin
            if (cond) pc_op = PC_INC;
          end
        end
      end
      REQ:     state_nxt = CAP;
      CAP: begin
        state_nxt = DONE;
        pc_op     = PC_INC;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      imem_addr <= RESET_PC;
      collision <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      collision <= collision | collide;
      if (fetch_go)      imem_addr <= pc;
      if (state == CAP)  instr     <= imem_rdata;
    end
  end

  assign imem_en     = (state == REQ);
  assign instr_valid = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a BRAM model returns 0xA000_0000+addr,
// each accepted fetch pushes its expected instr/pc/latency for the monitor.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        top_en = 1'b1;
  logic        IF = 1'b0, JU = 1'b0, BR = 1'b0, SK = 1'b0, cond = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] br_offset = '0;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        busy;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] mpc = 16'h0000;

  pc_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .top_en      (top_en),
    .IF          (IF),
    .JU          (JU),
    .BR          (BR),
    .SK          (SK),
    .cond        (cond),
    .jump_target (jump_target),
    .br_offset   (br_offset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (imem_en) imem_rdata <= 32'hA000_0000 + {16'h0000, imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every instr_valid pulse must match the oldest expected fetch.
  always @(negedge clk) begin
    if (instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", {16'h0, pc}, {16'h0, e.pc});
        chk("sb_latency", cyc, e.cyc);
      end
    end
  end

  task automatic strobe(input logic i, input logic j, input logic b, input logic s, input logic c);
    IF = i; JU = j; BR = b; SK = s; cond = c;
    @(negedge clk);
    IF = 1'b0; JU = 1'b0; BR = 1'b0; SK = 1'b0; cond = 1'b0;
  endtask

  task automatic fetch(input string tag);
    exp_t e;
    e.instr = 32'hA000_0000 + {16'h0000, mpc};
    e.pc    = mpc + 16'd1;
    e.cyc   = cyc + 3;
    sb.push_back(e);
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_imem_en"}, {31'h0, imem_en}, 32'd1);
    chk({tag, "_imem_addr"}, {16'h0, imem_addr}, {16'h0, mpc});
    chk({tag, "_busy"}, {31'h0, busy}, 32'd1);
    mpc = mpc + 16'd1;
    repeat (3) @(negedge clk);
  endtask

  task automatic jump(input logic [15:0] t);
    jump_target = t;
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mpc = t;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_imem_en", {31'h0, imem_en}, 32'd0);
    chk("rst_imem_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // sequential fetch
    fetch("seq0");
    fetch("seq1");
    fetch("seq2");
    chk("seq_pc", {16'h0, pc}, 32'd3);

    // jump to top of memory, fetch wraps pc
    jump(16'hFFFF);
    chk("ju_pc", {16'h0, pc}, 32'h0000_FFFF);
    fetch("wrap");
    chk("wrap_pc", {16'h0, pc}, 32'h0);

    // branch taken backwards, then not taken
    jump(16'h0010);
    br_offset = 16'hFFFC;
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("br_taken", {16'h0, pc}, 32'h0000_000C);
    br_offset = 16'h0100;
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_not_taken", {16'h0, pc}, 32'h0000_000C);

    // skip taken / not taken
    jump(16'h0005);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sk_taken", {16'h0, pc}, 32'd6);
    strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sk_not_taken", {16'h0, pc}, 32'd6);
    chk("no_collision_yet", {31'h0, dut.collision}, 32'd0);

    // JU+BR together: jump wins, collision latches
    jump_target = 16'h0040;
    br_offset   = 16'h0008;
    strobe(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    mpc = 16'h0040;
    chk("collide_pc", {16'h0, pc}, 32'h0000_0040);
    chk("collision", {31'h0, dut.collision}, 32'd1);

    // second IF while busy is dropped
    begin
      exp_t e;
      e.instr = 32'hA000_0000 + {16'h0000, mpc};
      e.pc    = mpc + 16'd1;
      e.cyc   = cyc + 3;
      sb.push_back(e);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      mpc = mpc + 16'd1;
      repeat (6) @(negedge clk);
      chk("busy_drop_pc", {16'h0, pc}, {16'h0, mpc});
      chk("busy_drop_idle", {31'h0, busy}, 32'd0);
    end

    // top_en low blocks fetch and redirect
    top_en = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_imem_en", {31'h0, imem_en}, 32'd0);
    chk("dis_busy", {31'h0, busy}, 32'd0);
    jump_target = 16'h1234;
    strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("dis_pc", {16'h0, pc}, {16'h0, mpc});
    top_en = 1'b1;

    // top_en dropping mid-fetch lets the fetch finish
    begin
      exp_t e;
      e.instr = 32'hA000_0000 + {16'h0000, mpc};
      e.pc    = mpc + 16'd1;
      e.cyc   = cyc + 3;
      sb.push_back(e);
      strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      top_en = 1'b0;
      mpc = mpc + 16'd1;
      repeat (4) @(negedge clk);
      chk("en_drop_pc", {16'h0, pc}, {16'h0, mpc});
      top_en = 1'b1;
    end

    // reset during CAP discards the fetch
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_cap", {30'h0, dut.state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_imem_en", {31'h0, imem_en}, 32'd0);
    chk("midrst_pc", {16'h0, pc}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_collision", {31'h0, dut.collision}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mpc = 16'h0000;
    repeat (3) @(negedge clk);
    chk("post_rst_pc", {16'h0, pc}, 32'h0);
    fetch("post_rst");

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
